// File: rtl/enemy_pkg.sv
// Shared slot-state encoding and default tuning constants for the enemy array.
package enemy_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ACTIVE = 2'd1,
        DYING  = 2'd2
    } slot_state_t;

    localparam int STEP_DEF      = 10;
    localparam int Y_MAX_DEF     = 470;
    localparam int DIE_TICKS_DEF = 3;

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: FREE/ACTIVE/DYING state, vertical position and explosion down-counter.
// state  | meaning
// FREE   | unused, may be allocated by a spawn
// ACTIVE | falling one step per tick, collidable
// DYING  | frozen at hit position until the counter runs out on ticks
module enemy_slot
    import enemy_pkg::*;
#(
    parameter int Y_W       = 10,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int DIE_TICKS = DIE_TICKS_DEF,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             hit_i,
    input  logic             alloc_i,
    input  logic [Y_W:0]     step_i,
    output slot_state_t      state_o,
    output logic [Y_W-1:0]   y_o,
    output logic             escape_o,
    output logic             kill_o
);

    localparam logic [Y_W:0]   Y_MAX_L = (Y_W+1)'(Y_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIE_TICKS);

    slot_state_t      state_q, state_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [Y_W:0]     y_sum;

    // One extra bit so a step past the bottom never wraps back on screen.
    assign y_sum = {1'b0, y_q} + step_i;

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        escape_o = 1'b0;
        kill_o   = 1'b0;
        case (state_q)
            FREE: begin
                if (alloc_i) begin
                    state_d = ACTIVE;
                    y_d     = '0;
                end
            end
            ACTIVE: begin
                if (hit_i) begin
                    state_d = DYING;
                    cnt_d   = CNT_INIT;
                    kill_o  = 1'b1;
                end else if (tick_i) begin
                    if (y_sum > Y_MAX_L) begin
                        state_d  = FREE;
                        y_d      = '0;
                        escape_o = 1'b1;
                    end else begin
                        y_d = y_sum[Y_W-1:0];
                    end
                end
            end
            DYING: begin
                if (tick_i) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = FREE;
                        y_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign y_o     = y_q;

endmodule

// File: rtl/enemy_array.sv
// Array of falling enemy slots with lowest-index spawn allocation, escape flag and kill counter.
// Optional macro ENEMY_ARRAY_SPEEDUP_EN: per-tick step grows with kill_count, capped at 2*STEP.
module enemy_array
    import enemy_pkg::*;
#(
    parameter int N_ENEMIES = 4,
    parameter int Y_W       = 10,
    parameter int STEP      = STEP_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int DIE_TICKS = DIE_TICKS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     spawn_req,
    output logic                     spawn_ack,
    input  logic [N_ENEMIES-1:0]     collision,
    output logic [N_ENEMIES*Y_W-1:0] enemy_y,
    output logic [N_ENEMIES-1:0]     exists,
    output logic [N_ENEMIES-1:0]     dying,
    output logic                     escaped,
    output logic [7:0]               kill_count
);

    localparam int CNT_W = (DIE_TICKS < 1) ? 1 : $clog2(DIE_TICKS + 1);

    slot_state_t          slot_state [N_ENEMIES];
    logic [N_ENEMIES-1:0] alloc_vec;
    logic [N_ENEMIES-1:0] esc_vec;
    logic [N_ENEMIES-1:0] kill_vec;
    logic [Y_W:0]         step;
    logic                 found;
    logic [4:0]           hit_cnt;
    logic [8:0]           kill_sum;

    logic       spawn_ack_q, escaped_q;
    logic [7:0] kill_count_q, kill_count_d;

`ifdef ENEMY_ARRAY_SPEEDUP_EN
    localparam logic [Y_W:0] STEP_MAX = (Y_W+1)'(2 * STEP);
    logic [Y_W:0] step_raw;
    assign step_raw = (Y_W+1)'(STEP) + (Y_W+1)'(kill_count_q[7:3]);
    assign step     = (step_raw > STEP_MAX) ? STEP_MAX : step_raw;
`else
    assign step = (Y_W+1)'(STEP);
`endif

    // Allocation looks only at pre-edge state, so a slot freed this cycle waits a cycle.
    always_comb begin
        alloc_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (!found && slot_state[i] == FREE) begin
                alloc_vec[i] = spawn_req;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            hit_cnt = hit_cnt + 5'(kill_vec[i]);
        end
        kill_sum     = {1'b0, kill_count_q} + 9'(hit_cnt);
        kill_count_d = (kill_sum > 9'd255) ? 8'hFF : kill_sum[7:0];
    end

    for (genvar g = 0; g < N_ENEMIES; g++) begin : g_slot
        enemy_slot #(
            .Y_W       (Y_W),
            .Y_MAX     (Y_MAX),
            .DIE_TICKS (DIE_TICKS),
            .CNT_W     (CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .hit_i    (collision[g]),
            .alloc_i  (alloc_vec[g]),
            .step_i   (step),
            .state_o  (slot_state[g]),
            .y_o      (enemy_y[g*Y_W +: Y_W]),
            .escape_o (esc_vec[g]),
            .kill_o   (kill_vec[g])
        );
        assign exists[g] = (slot_state[g] == ACTIVE);
        assign dying[g]  = (slot_state[g] == DYING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_ack_q  <= 1'b0;
            escaped_q    <= 1'b0;
            kill_count_q <= '0;
        end else begin
            spawn_ack_q  <= |alloc_vec;
            escaped_q    <= |esc_vec;
            kill_count_q <= kill_count_d;
        end
    end

    assign spawn_ack  = spawn_ack_q;
    assign escaped    = escaped_q;
    assign kill_count = kill_count_q;

endmodule
